aes_block_gearbox: RTL and testbench
====================================

# aes_block_gearbox

Width-conversion and buffering stage between the HWPE streamers and the AES core datapath. It packs four 32-bit plaintext words from the source stream into one 128-bit block for the core, and unpacks each 128-bit ciphertext result into four 32-bit words for the sink stream. The gather and scatter halves run independently, so the next plaintext block can be loaded while the current result drains. The AES control FSM uses `busy_o` and `done_o` for sequencing.

## Interface
Parameters:
- WORD_W, 32, stream word width; fixed at 32 for this revision.
- WORDS, 4, words per block; block width is WORD_W*WORDS = 128.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous soft clear; same effect as reset.
- in_data_i  in  32  plaintext word from source streamer.
- in_valid_i  in  1  plaintext word valid.
- in_ready_o  out  1  gearbox can accept a plaintext word.
- blk_data_o  out  128  assembled plaintext block to AES core.
- blk_valid_o  out  1  block valid.
- blk_ready_i  in  1  core accepts block.
- res_data_i  in  128  ciphertext block from AES core.
- res_valid_i  in  1  result valid.
- res_ready_o  out  1  gearbox can accept a result.
- out_data_o  out  32  ciphertext word to sink streamer.
- out_valid_o  out  1  ciphertext word valid.
- out_ready_i  in  1  sink accepts word.
- in_count_o  out  2  plaintext words held in the current partial block.
- out_count_o  out  2  ciphertext words already emitted from the current result.
- busy_o  out  1  high when either half is not idle.
- done_o  out  1  one-cycle pulse on the last ciphertext word handshake of a block.

## Operation
- Handshakes:
  - A transfer occurs when valid and ready are both high on a rising edge.
  - A valid signal, once raised, holds its data stable until the transfer.
- Gather FSM:
  - G_FILL: in_ready_o=1. Each input transfer writes the word into slot in_count_o and increments the count.
  - Word 0 goes to bits [127:96], word 1 to [95:64], word 2 to [63:32], word 3 to [31:0].
  - The transfer with in_count_o=3 wraps the count to 0 and moves to G_HOLD.
  - G_HOLD: in_ready_o=0, blk_valid_o=1. A block transfer returns the FSM to G_FILL.
- Scatter FSM:
  - S_EMPTY: res_ready_o=1. A result transfer latches res_data_i and moves to S_DRAIN.
  - S_DRAIN: res_ready_o=0, out_valid_o=1. out_data_o is slot out_count_o, using the same slot-to-bits mapping as gather (slot 0 = bits [127:96] first).
  - Each output transfer increments out_count_o.
  - The transfer with out_count_o=3 pulses done_o, wraps the count to 0 and returns to S_EMPTY.
- busy_o = (gather state != G_FILL) | (in_count_o != 0) | (scatter state != S_EMPTY).
- The two FSMs are fully independent. Simultaneous events on both sides in one cycle are all honoured.
- clear or reset:
  - Both FSMs go to their idle states, counts go to 0, data registers go to 0.
  - Any handshake in the same cycle as clear is discarded.
  - A partial block mid-fill or mid-drain is lost.

## Timing
- Reset values: in_ready_o=1, res_ready_o=1. All other outputs are 0.
- Ready and valid outputs are registered state decodes only, with no combinational path from any input.
- Latencies:
  - blk_valid_o rises the cycle after the 4th input transfer.
  - out_valid_o rises the cycle after the result transfer. out_data_o equals slot 0 in that same cycle.
- Throughput: 4 input words plus 1 block transfer per block is 5 cycles minimum. Drain side is likewise 5 cycles minimum.
- done_o is high in the cycle of the final output transfer, combinationally from out_ready_i in S_DRAIN with out_count_o=3.

## Configuration
- AES_GEARBOX_BYTESWAP_EN:
  - Defined: every 32-bit word is byte-reversed on entry (in_data_i[7:0] lands in the slot's MSB byte) and byte-reversed again on exit. This maps little-endian memory to AES byte order.
  - Undefined: words pass unmodified.

## Test plan
- Basic gather, macro off:
  - Stimulus: input 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF with blk_ready_i=1.
  - Required: blk_data_o=0x00112233_44556677_8899AABB_CCDDEEFF for exactly one cycle, in_ready_o low that cycle.
- Backpressure on block side:
  - Stimulus: blk_ready_i=0 for 10 cycles after a full block.
  - Required: blk_valid_o held, data stable, in_ready_o=0, a 5th in_valid_i ignored.
- Basic scatter with stalls:
  - Stimulus: result 0x0123..CDEF with out_ready_i toggling 1,0,1,0.
  - Required: words emitted in order 0x01234567 first, each held during stalls, done_o pulses once on the 4th transfer.
- Overlap:
  - Stimulus: load the next plaintext block while a result drains.
  - Required: both complete, no corruption, busy_o stays 1 until both halves are idle.
- Clear mid-operation:
  - Stimulus: clear after 2 input words and 1 output word.
  - Required: counts=0, in_ready_o=1, res_ready_o=1, out_valid_o=0. A following fresh block is assembled correctly.
- Byte swap, macro on:
  - Stimulus: input word 0x00112233.
  - Required: block bits [127:96]=0x33221100, and the round-trip output word is 0x00112233.

Source files
------------

// File: rtl/aes_block_gearbox.sv
// aes_block_gearbox: packs four 32-bit plaintext words into a 128-bit block for
// the AES core, and unpacks each 128-bit result into four 32-bit words.
// Gather and scatter halves are independent so loading and draining overlap.
// Optional feature macro: AES_GEARBOX_BYTESWAP_EN (byte-reverse every word on
// entry and again on exit, mapping little-endian memory to AES byte order).
module aes_block_gearbox #(
    parameter int WORD_W = 32,
    parameter int WORDS  = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      clear,
    input  logic [WORD_W-1:0]         in_data_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    output logic [WORD_W*WORDS-1:0]   blk_data_o,
    output logic                      blk_valid_o,
    input  logic                      blk_ready_i,
    input  logic [WORD_W*WORDS-1:0]   res_data_i,
    input  logic                      res_valid_i,
    output logic                      res_ready_o,
    output logic [WORD_W-1:0]         out_data_o,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [$clog2(WORDS)-1:0]  in_count_o,
    output logic [$clog2(WORDS)-1:0]  out_count_o,
    output logic                      busy_o,
    output logic                      done_o
);

    localparam int BLK_W = WORD_W * WORDS;
    localparam int CNT_W = $clog2(WORDS);
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(WORDS - 1);

    typedef enum logic {
        G_FILL = 1'b0,
        G_HOLD = 1'b1
    } g_state_e;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_DRAIN = 1'b1
    } s_state_e;

    g_state_e           g_state_q, g_state_d;
    s_state_e           s_state_q, s_state_d;
    logic [CNT_W-1:0]   in_count_q, in_count_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;
    logic [BLK_W-1:0]   blk_q, blk_d;
    logic [BLK_W-1:0]   res_q, res_d;

    logic               in_fire;
    logic               blk_fire;
    logic               res_fire;
    logic               out_fire;
    logic               in_last;
    logic               out_last;
    logic [WORD_W-1:0]  in_word;
    logic [WORD_W-1:0]  out_word_raw;
    logic [WORDS-1:0]   slot_we;
    logic [WORD_W-1:0]  res_slot [WORDS];

    // Reverse the byte order of one stream word.
    function automatic logic [WORD_W-1:0] swap_bytes(input logic [WORD_W-1:0] w);
        logic [WORD_W-1:0] r;
        r = '0;
        for (int b = 0; b < WORD_W / 8; b++) begin
            r[8*b +: 8] = w[WORD_W-8-8*b +: 8];
        end
        return r;
    endfunction

    // Handshake decodes; ready/valid come only from state.
    assign in_fire  = (g_state_q == G_FILL) && in_valid_i;
    assign blk_fire = (g_state_q == G_HOLD) && blk_ready_i;
    assign res_fire = (s_state_q == S_EMPTY) && res_valid_i;
    assign out_fire = (s_state_q == S_DRAIN) && out_ready_i;
    assign in_last  = (in_count_q == LAST_SLOT);
    assign out_last = (out_count_q == LAST_SLOT);

`ifdef AES_GEARBOX_BYTESWAP_EN
    assign in_word    = swap_bytes(in_data_i);
    assign out_data_o = swap_bytes(out_word_raw);
`else
    assign in_word    = in_data_i;
    assign out_data_o = out_word_raw;
`endif

    // Slot 0 occupies the most significant word of the block on both sides.
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_slot
        assign slot_we[gi]  = in_fire && (in_count_q == CNT_W'(gi));
        assign res_slot[gi] = res_q[BLK_W-WORD_W*(gi+1) +: WORD_W];
    end

    assign out_word_raw = res_slot[out_count_q];

    // Gather half: fill slots, then hold the block until the core takes it.
    always_comb begin
        g_state_d  = g_state_q;
        in_count_d = in_count_q;
        blk_d      = blk_q;
        for (int i = 0; i < WORDS; i++) begin
            if (slot_we[i]) begin
                blk_d[BLK_W-WORD_W*(i+1) +: WORD_W] = in_word;
            end
        end
        if (in_fire) begin
            in_count_d = in_count_q + 1'b1;
            if (in_last) begin
                g_state_d = G_HOLD;
            end
        end
        if (blk_fire) begin
            g_state_d = G_FILL;
        end
        if (clear) begin
            g_state_d  = G_FILL;
            in_count_d = '0;
            blk_d      = '0;
        end
    end

    // Scatter half: latch a result, then emit its words one per transfer.
    always_comb begin
        s_state_d   = s_state_q;
        out_count_d = out_count_q;
        res_d       = res_q;
        if (res_fire) begin
            res_d     = res_data_i;
            s_state_d = S_DRAIN;
        end
        if (out_fire) begin
            out_count_d = out_count_q + 1'b1;
            if (out_last) begin
                s_state_d = S_EMPTY;
            end
        end
        if (clear) begin
            s_state_d   = S_EMPTY;
            out_count_d = '0;
            res_d       = '0;
        end
    end

    // State and data registers for both halves.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            g_state_q   <= G_FILL;
            s_state_q   <= S_EMPTY;
            in_count_q  <= '0;
            out_count_q <= '0;
            blk_q       <= '0;
            res_q       <= '0;
        end else begin
            g_state_q   <= g_state_d;
            s_state_q   <= s_state_d;
            in_count_q  <= in_count_d;
            out_count_q <= out_count_d;
            blk_q       <= blk_d;
            res_q       <= res_d;
        end
    end

    assign in_ready_o  = (g_state_q == G_FILL);
    assign blk_valid_o = (g_state_q == G_HOLD);
    assign blk_data_o  = blk_q;
    assign res_ready_o = (s_state_q == S_EMPTY);
    assign out_valid_o = (s_state_q == S_DRAIN);
    assign in_count_o  = in_count_q;
    assign out_count_o = out_count_q;
    assign busy_o      = (g_state_q != G_FILL) || (in_count_q != '0) ||
                         (s_state_q != S_EMPTY);
    // A final-word transfer coinciding with clear is discarded, so no pulse.
    assign done_o      = out_fire && out_last && !clear;

endmodule

// File: tb/tb_aes_block_gearbox.sv
// Directed testbench for aes_block_gearbox; expectations hand-computed.
// Passes with AES_GEARBOX_BYTESWAP_EN either defined or undefined.
module tb_aes_block_gearbox;

    logic         clk;
    logic         reset_n;
    logic         clear;
    logic [31:0]  in_data_i;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [127:0] blk_data_o;
    logic         blk_valid_o;
    logic         blk_ready_i;
    logic [127:0] res_data_i;
    logic         res_valid_i;
    logic         res_ready_o;
    logic [31:0]  out_data_o;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [1:0]   in_count_o;
    logic [1:0]   out_count_o;
    logic         busy_o;
    logic         done_o;

    int checks = 0;
    int errors = 0;

    aes_block_gearbox #(.WORD_W(32), .WORDS(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (clear),
        .in_data_i   (in_data_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .blk_data_o  (blk_data_o),
        .blk_valid_o (blk_valid_o),
        .blk_ready_i (blk_ready_i),
        .res_data_i  (res_data_i),
        .res_valid_i (res_valid_i),
        .res_ready_o (res_ready_o),
        .out_data_o  (out_data_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .in_count_o  (in_count_o),
        .out_count_o (out_count_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word transform the bench expects on entry/exit for the active build.
    function automatic logic [31:0] bs(input logic [31:0] w);
`ifdef AES_GEARBOX_BYTESWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    function automatic logic [31:0] slot(input logic [127:0] b, input int k);
        return b[127-32*k -: 32];
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load4(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] d);
        logic [31:0] w [4];
        w[0] = a; w[1] = b; w[2] = c; w[3] = d;
        for (int i = 0; i < 4; i++) begin
            in_valid_i = 1'b1;
            in_data_i  = w[i];
            tick();
        end
        in_valid_i = 1'b0;
    endtask

    logic [127:0] exp_blk;
    logic [127:0] r1, r2, r3;
    int idx;
    int dones;

    initial begin
        reset_n     = 1'b0;
        clear       = 1'b0;
        in_data_i   = '0;
        in_valid_i  = 1'b0;
        blk_ready_i = 1'b0;
        res_data_i  = '0;
        res_valid_i = 1'b0;
        out_ready_i = 1'b0;
        r1 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
        r2 = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
        r3 = 128'h11223344_55667788_99AABBCC_DDEEFF00;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready_o, 1);
        chk("rst_res_ready", res_ready_o, 1);
        chk("rst_blk_valid", blk_valid_o, 0);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_blk_data", blk_data_o, 0);
        chk("rst_out_data", out_data_o, 0);
        chk("rst_counts", {in_count_o, out_count_o}, 0);
        chk("rst_busy_done", {busy_o, done_o}, 0);
        reset_n = 1'b1;
        tick();
        chk("post_rst_in_ready", in_ready_o, 1);

        // Basic gather with the core always ready
        blk_ready_i = 1'b1;
        in_valid_i = 1'b1; in_data_i = 32'h00112233; tick();
        in_data_i = 32'h44556677; tick();
        chk("gather_count2", in_count_o, 2);
        chk("gather_busy", busy_o, 1);
        in_data_i = 32'h8899AABB; tick();
        in_data_i = 32'hCCDDEEFF; tick();
        in_valid_i = 1'b0;
        exp_blk = {bs(32'h00112233), bs(32'h44556677), bs(32'h8899AABB), bs(32'hCCDDEEFF)};
        chk("gather_blk_valid", blk_valid_o, 1);
        chk("gather_blk_data", blk_data_o, exp_blk);
        chk("gather_in_ready", in_ready_o, 0);
        chk("gather_count_wrap", in_count_o, 0);
        tick();
        chk("gather_blk_valid_1cyc", blk_valid_o, 0);
        chk("gather_in_ready_back", in_ready_o, 1);
        chk("gather_idle", busy_o, 0);

        // Backpressure on the block side; a 5th word must be ignored
        blk_ready_i = 1'b0;
        load4(32'h10101010, 32'h20202020, 32'h30303030, 32'h40404040);
        exp_blk = {bs(32'h10101010), bs(32'h20202020), bs(32'h30303030), bs(32'h40404040)};
        in_valid_i = 1'b1;
        in_data_i  = 32'hDEADBEEF;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("bp_blk_valid", blk_valid_o, 1);
            chk("bp_blk_data", blk_data_o, exp_blk);
            chk("bp_in_ready", in_ready_o, 0);
        end
        in_valid_i  = 1'b0;
        blk_ready_i = 1'b1;
        tick();
        blk_ready_i = 1'b0;
        chk("bp_released", blk_valid_o, 0);
        chk("bp_5th_ignored_count", in_count_o, 0);
        chk("bp_5th_ignored_data", blk_data_o, exp_blk);

        // Scatter with sink stalls 1,0,1,0,...
        res_data_i  = r1;
        res_valid_i = 1'b1;
        tick();
        res_valid_i = 1'b0;
        res_data_i  = '0;
        chk("sc_out_valid", out_valid_o, 1);
        chk("sc_first_word", out_data_o, bs(32'h01234567));
        chk("sc_res_ready", res_ready_o, 0);
        idx = 0;
        dones = 0;
        for (int c = 0; c < 7; c++) begin
            out_ready_i = (c % 2 == 0);
            #1;
            chk("sc_word", out_data_o, bs(slot(r1, idx)));
            chk("sc_valid_held", out_valid_o, 1);
            chk("sc_done", done_o, (out_ready_i && idx == 3));
            if (done_o) dones++;
            tick();
            if (out_ready_i) idx++;
        end
        out_ready_i = 1'b0;
        chk("sc_done_once", dones, 1);
        chk("sc_empty_valid", out_valid_o, 0);
        chk("sc_empty_ready", res_ready_o, 1);
        chk("sc_count_wrap", out_count_o, 0);

        // Overlap: load a block while a result drains
        res_data_i  = r2;
        res_valid_i = 1'b1;
        in_valid_i  = 1'b1;
        in_data_i   = 32'hC0FFEE00;
        tick();
        res_valid_i = 1'b0;
        chk("ov_busy0", busy_o, 1);
        chk("ov_in_count1", in_count_o, 1);
        chk("ov_out_valid", out_valid_o, 1);
        for (int k = 0; k < 4; k++) begin
            in_valid_i  = (k < 3);
            in_data_i   = 32'hC0FFEE01 + k;
            out_ready_i = 1'b1;
            #1;
            chk("ov_word", out_data_o, bs(slot(r2, k)));
            chk("ov_done", done_o, (k == 3));
            chk("ov_busy", busy_o, 1);
            tick();
        end
        out_ready_i = 1'b0;
        in_valid_i  = 1'b0;
        exp_blk = {bs(32'hC0FFEE00), bs(32'hC0FFEE01), bs(32'hC0FFEE02), bs(32'hC0FFEE03)};
        chk("ov_blk_valid", blk_valid_o, 1);
        chk("ov_blk_data", blk_data_o, exp_blk);
        chk("ov_drained", out_valid_o, 0);
        chk("ov_busy_gather", busy_o, 1);
        blk_ready_i = 1'b1;
        tick();
        blk_ready_i = 1'b0;
        chk("ov_idle", busy_o, 0);

        // Clear after 2 input words and 1 output word
        res_data_i  = r3;
        res_valid_i = 1'b1;
        tick();
        res_valid_i = 1'b0;
        in_valid_i  = 1'b1;
        in_data_i   = 32'hAAAA0001;
        out_ready_i = 1'b1;
        tick();
        in_data_i   = 32'hAAAA0002;
        out_ready_i = 1'b0;
        tick();
        in_valid_i  = 1'b0;
        chk("cl_pre_counts", {in_count_o, out_count_o}, {2'd2, 2'd1});
        clear       = 1'b1;
        in_valid_i  = 1'b1;
        in_data_i   = 32'hBADBAD00;
        out_ready_i = 1'b1;
        tick();
        clear       = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        chk("cl_counts", {in_count_o, out_count_o}, 0);
        chk("cl_in_ready", in_ready_o, 1);
        chk("cl_res_ready", res_ready_o, 1);
        chk("cl_out_valid", out_valid_o, 0);
        chk("cl_blk_data", blk_data_o, 0);
        chk("cl_busy", busy_o, 0);
        load4(32'h0BADF00D, 32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C);
        exp_blk = {bs(32'h0BADF00D), bs(32'h12345678), bs(32'h9ABCDEF0), bs(32'h0F1E2D3C)};
        chk("cl_fresh_valid", blk_valid_o, 1);
        chk("cl_fresh_data", blk_data_o, exp_blk);
        blk_ready_i = 1'b1;
        tick();
        blk_ready_i = 1'b0;

`ifdef AES_GEARBOX_BYTESWAP_EN
        // Byte swap on entry and on exit
        load4(32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF);
        chk("bs_slot0", blk_data_o[127:96], 32'h33221100);
        blk_ready_i = 1'b1;
        tick();
        blk_ready_i = 1'b0;
        res_data_i  = 128'h33221100_77665544_BBAA9988_FFEEDDCC;
        res_valid_i = 1'b1;
        tick();
        res_valid_i = 1'b0;
        chk("bs_roundtrip", out_data_o, 32'h00112233);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
